// File: rtl/divider_arbiter_32_if.sv
// Request/response handshake bundle for the two clients of divider_arbiter_32.
// rsp_q/rsp_rem/rsp_dbz are shared and qualified by the per-port rsp valids.
interface divider_arbiter_32_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_signed;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_signed;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_q;
    logic [31:0] rsp_rem;
    logic        rsp_dbz;

    modport master (
        output req0_valid, req0_a, req0_b, req0_signed,
        output req1_valid, req1_a, req1_b, req1_signed,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_q, rsp_rem, rsp_dbz
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_signed,
        input  req1_valid, req1_a, req1_b, req1_signed,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_q, rsp_rem, rsp_dbz
    );
endinterface

// File: rtl/divider_arbiter_32.sv
// Shares one external combinational unsigned divider between two requesters,
// round-robin arbitrated, with sign correction and divide-by-zero handling.
module divider_arbiter_32 #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    divider_arbiter_32_if.slave  bus,
    output logic [31:0]          div_a,
    output logic [31:0]          div_b,
    input  logic [31:0]          div_q,
    input  logic [31:0]          div_rem,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t      state_reg;
    logic        rr_ptr_reg;
    logic        id_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] div_a_reg;
    logic [31:0] div_b_reg;
    logic [31:0] q_reg;
    logic [31:0] rem_reg;
    logic        dbz_reg;

    logic        grant;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic        rsp_accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sign_a_next;
    logic        sign_b_next;

    // A lone requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        grant = rr_ptr_reg;
        if (bus.req0_valid && !bus.req1_valid)
            grant = 1'b0;
        else if (!bus.req0_valid && bus.req1_valid)
            grant = 1'b1;
    end

    assign ready0      = !reset && (state_reg == IDLE) && !grant && bus.req0_valid;
    assign ready1      = !reset && (state_reg == IDLE) &&  grant && bus.req1_valid;
    assign accept      = ready0 || ready1;
    assign sel_a       = grant ? bus.req1_a : bus.req0_a;
    assign sel_b       = grant ? bus.req1_b : bus.req0_b;
    assign sign_a_next = sel_a[31] && (grant ? bus.req1_signed : bus.req0_signed);
    assign sign_b_next = sel_b[31] && (grant ? bus.req1_signed : bus.req0_signed);
    assign rsp_accept  = (bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            id_reg     <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            cnt_reg    <= 4'd0;
            div_a_reg  <= 32'd0;
            div_b_reg  <= 32'd0;
            q_reg      <= 32'd0;
            rem_reg    <= 32'd0;
            dbz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        id_reg     <= grant;
                        sign_a_reg <= sign_a_next;
                        sign_b_reg <= sign_b_next;
                        div_a_reg  <= sign_a_next ? 32'd0 - sel_a : sel_a;
                        div_b_reg  <= sign_b_next ? 32'd0 - sel_b : sel_b;
                        rr_ptr_reg <= ~grant;
                        if (sel_b == 32'd0) begin
                            q_reg     <= 32'hFFFF_FFFF;
                            rem_reg   <= sel_a;
                            dbz_reg   <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            cnt_reg   <= 4'(SETTLE_CYCLES - 1);
                            state_reg <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    // div_q/div_rem are a multicycle path; sample only once the count expires.
                    if (cnt_reg == 4'd0) begin
                        q_reg     <= (sign_a_reg ^ sign_b_reg) ? 32'd0 - div_q : div_q;
                        rem_reg   <= sign_a_reg ? 32'd0 - div_rem : div_rem;
                        dbz_reg   <= 1'b0;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_accept)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = (state_reg == RESP) && !id_reg;
    assign bus.rsp1_valid = (state_reg == RESP) &&  id_reg;
    assign bus.rsp_q      = q_reg;
    assign bus.rsp_rem    = rem_reg;
    assign bus.rsp_dbz    = dbz_reg;
    assign div_a          = div_a_reg;
    assign div_b          = div_b_reg;
    assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_divider_arbiter_32.sv
// Self-checking bench for divider_arbiter_32: directed cases, randomized traffic
// against a 64-bit arithmetic reference model, arbitration, back-pressure and reset.
module tb_divider_arbiter_32;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q;
    logic [31:0] div_rem;
    logic        busy;
    int          passed = 0;
    int          total  = 0;

    divider_arbiter_32_if bus();

    divider_arbiter_32 #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .div_a   (div_a),
        .div_b   (div_b),
        .div_q   (div_q),
        .div_rem (div_rem),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external unsigned divider_32.
    assign div_q   = (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
    assign div_rem = (div_b == 32'd0) ? div_a : div_a % div_b;

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] rem, output logic d);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; rem = a; d = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0]; rem = lr[31:0]; d = 1'b0;
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_signed = s;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_signed = s;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) bus.rsp0_ready = v; else bus.rsp1_ready = v;
    endtask

    function automatic logic get_ready(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic get_rsp_valid(input int p);
        return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    // Issues one request, counts edges (accept edge = 1) until the response, then consumes it.
    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [31:0] q, output logic [31:0] rem,
                          output logic d, output bit ok);
        ok = 0; lat = 0; q = '0; rem = '0; d = 1'b0;
        @(negedge clk);
        set_req(p, 1'b1, a, b, s);
        for (int i = 0; i < 50; i++) begin
            #1;
            if (get_ready(p)) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin set_req(p, 1'b0, '0, '0, 1'b0); return; end
        @(posedge clk); #1;
        set_req(p, 1'b0, '0, '0, 1'b0);
        ok = 0; lat = 1;
        for (int i = 0; i < 50; i++) begin
            if (get_rsp_valid(p)) begin ok = 1; break; end
            @(posedge clk); #1;
            lat++;
        end
        if (!ok) return;
        q = bus.rsp_q; rem = bus.rsp_rem; d = bus.rsp_dbz;
        set_rsp_ready(p, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(p, 1'b0);
        $display("txn port=%0d a=%h b=%h s=%0d q=%h rem=%h dbz=%0d lat=%0d", p, a, b, s, q, rem, d, lat);
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_dbz} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_dbz});
        else passed++;
        total++;
        if ({bus.rsp_q, bus.rsp_rem, div_a, div_b} !== 128'd0)
            $display("FAIL reset_data: got q=%h rem=%h div_a=%h div_b=%h want all 0",
                     bus.rsp_q, bus.rsp_rem, div_a, div_b);
        else passed++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta[4] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234};
        logic [31:0] tb[4] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0};
        logic        ts[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          tp[4] = '{0, 0, 1, 1};
        logic [31:0] eq[4] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] er[4] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'h1234};
        logic        ed[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          el[4] = '{SETTLE + 1, SETTLE + 1, SETTLE + 1, 1};
        int lat; logic [31:0] q, rem; logic d; bit ok;
        for (int i = 0; i < 4; i++) begin
            run_op(tp[i], ta[i], tb[i], ts[i], lat, q, rem, d, ok);
            total++;
            if (!ok) $display("FAIL dir%0d_handshake: got timeout want response", i);
            else passed++;
            total++;
            if ({q, rem, d} !== {eq[i], er[i], ed[i]})
                $display("FAIL dir%0d_result: got q=%h rem=%h dbz=%0d want q=%h rem=%h dbz=%0d",
                         i, q, rem, d, eq[i], er[i], ed[i]);
            else passed++;
            total++;
            if (lat !== el[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, el[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int lat, p, r; logic [31:0] a, b, q, rem, eq, er; logic s, d, ed; bit ok;
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            r = int'($urandom_range(0, 9));
            if (r == 0)      b = 32'd0;
            else if (r < 4)  b = $urandom_range(1, 20);
            else if (r == 4) b = 32'd0 - $urandom_range(1, 20);
            else             b = $urandom;
            ref_div(a, b, s, eq, er, ed);
            run_op(p, a, b, s, lat, q, rem, d, ok);
            total++;
            if (!ok || {q, rem, d} !== {eq, er, ed} || lat !== (ed ? 1 : SETTLE + 1))
                $display("FAIL rand%0d: got ok=%0d q=%h rem=%h dbz=%0d lat=%0d want q=%h rem=%h dbz=%0d lat=%0d",
                         i, ok, q, rem, d, lat, eq, er, ed, ed ? 1 : SETTLE + 1);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        int grants[$]; bit both = 0; bit drained = 0;
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'd50, 32'd3, 1'b0);
        set_req(1, 1'b1, 32'd60, 32'd4, 1'b0);
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 200 && grants.size() < 4; i++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both = 1;
            if (bus.req0_ready) grants.push_back(0);
            else if (bus.req1_ready) grants.push_back(1);
            @(negedge clk);
        end
        #1;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!busy) begin drained = 1; break; end
        end
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        $display("txn round_robin grants=%p", grants);
        total++;
        if (both || !drained || grants.size() != 4)
            $display("FAIL rr_overall: got two_ready=%0d drained=%0d grants=%0d want 0 1 4",
                     both, drained, grants.size());
        else passed++;
        for (int i = 0; i < grants.size(); i++) begin
            total++;
            if (grants[i] !== i % 2) $display("FAIL rr_grant%0d: got %0d want %0d", i, grants[i], i % 2);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] eq, er, cq, cr; logic ed; bit ok = 0; bit stable = 1;
        ref_div(32'd12345, 32'd67, 1'b0, eq, er, ed);
        @(negedge clk);
        set_req(0, 1'b1, 32'd12345, 32'd67, 1'b0);
        for (int i = 0; i < 50; i++) begin
            #1; if (bus.req0_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b1, 32'hFFFF_FF00, 32'd16, 1'b1);
        for (int i = 0; i < 50 && !bus.rsp0_valid; i++) begin @(posedge clk); #1; end
        cq = bus.rsp_q; cr = bus.rsp_rem;
        total++;
        if (!ok || !bus.rsp0_valid || cq !== eq || cr !== er)
            $display("FAIL bp_result: got ok=%0d valid=%0d q=%h rem=%h want 1 1 q=%h rem=%h",
                     ok, bus.rsp0_valid, cq, cr, eq, er);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bus.rsp0_valid || bus.rsp1_valid || bus.rsp_q !== cq || bus.rsp_rem !== cr || bus.req1_ready)
                stable = 0;
        end
        total++;
        if (!stable) $display("FAIL bp_hold: got unstable response or req1_ready during back-pressure want stable");
        else passed++;
        set_req(0, 1'b1, 32'd1, 32'd1, 1'b0);
        bus.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
            $display("FAIL bp_next_grant: got ready0=%0d ready1=%0d want 0 1", bus.req0_ready, bus.req1_ready);
        else passed++;
        set_req(0, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        set_req(1, 1'b0, '0, '0, 1'b0);
        ref_div(32'hFFFF_FF00, 32'd16, 1'b1, eq, er, ed);
        for (int i = 0; i < 50 && !bus.rsp1_valid; i++) begin @(posedge clk); #1; end
        total++;
        if (!bus.rsp1_valid || bus.rsp_q !== eq || bus.rsp_rem !== er || bus.rsp_dbz !== ed)
            $display("FAIL bp_port1: got valid=%0d q=%h rem=%h want 1 q=%h rem=%h",
                     bus.rsp1_valid, bus.rsp_q, bus.rsp_rem, eq, er);
        else passed++;
        $display("txn port=1 a=ffffff00 b=00000010 s=1 q=%h rem=%h (after back-pressure)", bus.rsp_q, bus.rsp_rem);
        bus.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] q, rem; logic d; bit ok = 0; bit quiet = 1;
        @(negedge clk);
        set_req(0, 1'b1, 32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 50; i++) begin
            #1; if (bus.req0_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (!ok || !busy || bus.rsp0_valid) $display("FAIL mid_settle: got ok=%0d busy=%0d valid=%0d want 1 1 0",
                                                    ok, busy, bus.rsp0_valid);
        else passed++;
        #1 reset = 1'b1;
        #1;
        total++;
        if ({busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_dbz} !== 6'b0 ||
            {bus.rsp_q, bus.rsp_rem, div_a, div_b} !== 128'd0)
            $display("FAIL mid_reset_values: got busy=%0d rsp0_valid=%0d q=%h rem=%h div_a=%h div_b=%h want all 0",
                     busy, bus.rsp0_valid, bus.rsp_q, bus.rsp_rem, div_a, div_b);
        else passed++;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.rsp0_valid || bus.rsp1_valid || busy) quiet = 0;
        end
        bus.rsp0_ready = 1'b0;
        total++;
        if (!quiet) $display("FAIL mid_no_rsp: got response or busy after reset want none");
        else passed++;
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, q, rem, d, ok);
        total++;
        if (!ok || {q, rem, d} !== {32'h8000_0000, 32'd0, 1'b0} || lat !== SETTLE + 1)
            $display("FAIL overflow: got ok=%0d q=%h rem=%h dbz=%0d lat=%0d want q=80000000 rem=0 dbz=0 lat=%0d",
                     ok, q, rem, d, lat, SETTLE + 1);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
